mult_seq_ctrl: RTL and testbench

- Sequential shift-and-add unsigned multiplier. Drives the select and operand inputs of the 3:1 accumulator mux (mux_three_to_one) and owns the accumulator register that takes the mux output.
- Sits directly upstream of the mux. The mux output is fed back into the block as the accumulator next-value.
- Start/ready handshake toward the top-level controller. One operand bit is processed per clock.

---
 rtl/mult_seq_ctrl_if.sv | 41 ++++
 rtl/mult_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if
//   Bundles the multiplier controller's handshake and accumulator-mux path.
//   Parameter N : operand width; product/accumulator width is 2N.
//   Signals:
//     iniciar        start request
//     multiplicando  unsigned multiplicand (N)
//     multiplicador  unsigned multiplier (N)
//     op             accumulator mux select (00 hold, 01 add, 10 clear)
//     a, b, c        mux inputs: hold value, add value, zero (2N)
//     saida_mux      mux output fed back as accumulator next value (2N)
//     produto        final product register (2N)
//     pronto         one-cycle "produto valid" pulse
//     ocupado        high while an operation is in progress
//   Modports:
//     master : surrounding logic (top-level controller and the mux)
//     slave  : mult_seq_ctrl
interface mult_seq_ctrl_if #(
    parameter int N = 5
);
    logic             iniciar;
    logic [N-1:0]     multiplicando;
    logic [N-1:0]     multiplicador;
    logic [1:0]       op;
    logic [2*N-1:0]   a;
    logic [2*N-1:0]   b;
    logic [2*N-1:0]   c;
    logic [2*N-1:0]   saida_mux;
    logic [2*N-1:0]   produto;
    logic             pronto;
    logic             ocupado;

    modport master (
        output iniciar, multiplicando, multiplicador, saida_mux,
        input  op, a, b, c, produto, pronto, ocupado
    );

    modport slave (
        input  iniciar, multiplicando, multiplicador, saida_mux,
        output op, a, b, c, produto, pronto, ocupado
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequential shift-and-add unsigned multiplier controller. Drives the
//   select and operands of the external 3:1 accumulator mux and holds the
//   accumulator, which reloads from the mux output in LOAD and CALC.
//   One multiplier bit is processed per clock.
//   Ports:
//     clock  : system clock, rising edge
//     reset  : asynchronous, active-high
//     bus    : mult_seq_ctrl_if.slave (handshake, operands, mux path, result)
//   Optional build macro:
//     MULT_EARLY_EXIT_EN : leave CALC as soon as the remaining multiplier
//                          bits are all zero (result unchanged, shorter latency)
module mult_seq_ctrl #(
    parameter int N = 5
) (
    input  logic                clock,
    input  logic                reset,
    mult_seq_ctrl_if.slave      bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  produto_r;
    logic            pronto_r;
    logic [N-1:0]    mcand;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   count;
    logic            last;

    // Mux operands: hold, add shifted multiplicand, clear.
    assign bus.a       = acc;
    assign bus.b       = acc + ({{N{1'b0}}, mcand} << count);
    assign bus.c       = '0;
    assign bus.produto = produto_r;
    assign bus.pronto  = pronto_r;

`ifdef MULT_EARLY_EXIT_EN
    // Done once no set multiplier bit remains above the current one.
    assign last = (count == CW'(N - 1)) || (((mplier >> count) >> 1) == '0);
`else
    assign last = (count == CW'(N - 1));
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        bus.op      = 2'b00;
        bus.ocupado = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iniciar) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                bus.op      = 2'b10;
                bus.ocupado = 1'b1;
                state_n     = CALC;
            end
            CALC: begin
                bus.op      = mplier[count] ? 2'b01 : 2'b00;
                bus.ocupado = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // pronto is registered together with produto so the pulse and the new
    // result appear in the same cycle, right after DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            produto_r <= '0;
            pronto_r  <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            pronto_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iniciar) begin
                        mcand  <= bus.multiplicando;
                        mplier <= bus.multiplicador;
                    end
                end
                LOAD: begin
                    acc   <= bus.saida_mux;
                    count <= '0;
                end
                CALC: begin
                    acc   <= bus.saida_mux;
                    count <= count + 1'b1;
                end
                DONE: begin
                    produto_r <= acc;
                    pronto_r  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
//   Directed bench for mult_seq_ctrl (N=5) with a behavioural 3:1 mux
//   closing the accumulator loop. Expected values are hand-computed.
module tb_mult_seq_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   passed;

    logic [1:0] op_tr   [12];
    logic       pr_tr   [12];
    logic       busy_tr [12];
    logic [9:0] prod_tr [12];

    mult_seq_ctrl_if #(.N(5)) bus ();

    mult_seq_ctrl #(.N(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // External accumulator mux.
    assign bus.saida_mux = (bus.op == 2'b01) ? bus.b :
                           (bus.op == 2'b10) ? bus.c : bus.a;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start one operation and record 12 samples, sample j taken 1 time unit
    // after edge k+j (edge k accepts the start). At sample inj a stray
    // 9x9 start is driven for one edge.
    task automatic run_op(input logic [4:0] mc, input logic [4:0] mp, input int inj);
        @(negedge clock);
        bus.multiplicando = mc;
        bus.multiplicador = mp;
        bus.iniciar       = 1'b1;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) begin
                @(posedge clock);
                #1;
            end
            op_tr[j]   = bus.op;
            pr_tr[j]   = bus.pronto;
            busy_tr[j] = bus.ocupado;
            prod_tr[j] = bus.produto;
            if (j == inj) begin
                bus.iniciar       = 1'b1;
                bus.multiplicando = 5'd9;
                bus.multiplicador = 5'd9;
            end else if (j == inj + 1) begin
                bus.iniciar = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.produto !== 10'd0) $display("FAIL reset_produto: got %0d expected 0", bus.produto); else passed++;
        checks++; if (bus.pronto !== 1'b0) $display("FAIL reset_pronto: got %b expected 0", bus.pronto); else passed++;
        checks++; if (bus.op !== 2'b00) $display("FAIL reset_op: got %b expected 00", bus.op); else passed++;
        checks++; if (bus.ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", bus.ocupado); else passed++;
    endtask

    task automatic test_basic();
        logic [1:0] exp_op [6];
        int lat;
        int np;
        int nb;
        exp_op[0] = 2'b10; exp_op[1] = 2'b00; exp_op[2] = 2'b01;
        exp_op[3] = 2'b01; exp_op[4] = 2'b00; exp_op[5] = 2'b00;
        run_op(5'd5, 5'd6, -1);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (op_tr[j] !== exp_op[j]) $display("FAIL basic_op[%0d]: got %b expected %b", j, op_tr[j], exp_op[j]);
            else passed++;
        end
        checks++; if (op_tr[6] !== 2'b00) $display("FAIL basic_op_done: got %b expected 00", op_tr[6]); else passed++;
        lat = -1; np = 0; nb = 0;
        for (int j = 0; j < 12; j++) begin
            if (pr_tr[j] === 1'b1) begin
                np++;
                if (lat < 0) lat = j;
            end
            if (busy_tr[j] === 1'b1) nb++;
        end
        checks++; if (lat != 7) $display("FAIL basic_latency: got %0d expected 7", lat); else passed++;
        checks++; if (np != 1) $display("FAIL basic_pronto_count: got %0d expected 1", np); else passed++;
        checks++; if (nb != 6) $display("FAIL basic_ocupado_cycles: got %0d expected 6", nb); else passed++;
        checks++; if (prod_tr[7] !== 10'd30) $display("FAIL basic_produto: got %0d expected 30", prod_tr[7]); else passed++;
        checks++; if (prod_tr[6] !== 10'd0) $display("FAIL basic_produto_before_done: got %0d expected 0", prod_tr[6]); else passed++;
        checks++; if (prod_tr[11] !== 10'd30) $display("FAIL basic_produto_hold: got %0d expected 30", prod_tr[11]); else passed++;
    endtask

    task automatic test_idle_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (bus.produto !== 10'd0) $display("FAIL idle_reset_produto: got %0d expected 0", bus.produto); else passed++;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
    endtask

    task automatic test_max_zero();
        int lat;
        run_op(5'd31, 5'd31, -1);
        checks++; if (prod_tr[7] !== 10'd961) $display("FAIL max_produto: got %0d expected 961", prod_tr[7]); else passed++;
        checks++; if (pr_tr[7] !== 1'b1) $display("FAIL max_pronto: got %b expected 1", pr_tr[7]); else passed++;
        run_op(5'd0, 5'd25, -1);
        lat = -1;
        for (int j = 0; j < 12; j++) if (pr_tr[j] === 1'b1 && lat < 0) lat = j;
        checks++; if (lat != 7) $display("FAIL zero_latency: got %0d expected 7", lat); else passed++;
        checks++; if (prod_tr[7] !== 10'd0) $display("FAIL zero_produto: got %0d expected 0", prod_tr[7]); else passed++;
    endtask

    task automatic test_busy_ignored();
        int np;
        run_op(5'd3, 5'd7, 2);
        np = 0;
        for (int j = 0; j < 12; j++) if (pr_tr[j] === 1'b1) np++;
        checks++; if (np != 1) $display("FAIL busy_pronto_count: got %0d expected 1", np); else passed++;
        checks++; if (prod_tr[7] !== 10'd21) $display("FAIL busy_produto: got %0d expected 21", prod_tr[7]); else passed++;
        checks++; if (prod_tr[11] !== 10'd21) $display("FAIL busy_produto_hold: got %0d expected 21", prod_tr[11]); else passed++;
        run_op(5'd9, 5'd9, -1);
        checks++; if (prod_tr[7] !== 10'd81) $display("FAIL busy_followup_produto: got %0d expected 81", prod_tr[7]); else passed++;
    endtask

    task automatic test_reset_mid_calc();
        int np;
        @(negedge clock);
        bus.multiplicando = 5'd12;
        bus.multiplicador = 5'd10;
        bus.iniciar       = 1'b1;
        @(posedge clock);
        #1;
        bus.iniciar = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checks++; if (bus.ocupado !== 1'b1) $display("FAIL midcalc_busy_before: got %b expected 1", bus.ocupado); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (bus.produto !== 10'd0) $display("FAIL midcalc_produto: got %0d expected 0", bus.produto); else passed++;
        checks++; if (bus.op !== 2'b00) $display("FAIL midcalc_op: got %b expected 00", bus.op); else passed++;
        checks++; if (bus.ocupado !== 1'b0) $display("FAIL midcalc_ocupado: got %b expected 0", bus.ocupado); else passed++;
        checks++; if (bus.pronto !== 1'b0) $display("FAIL midcalc_pronto: got %b expected 0", bus.pronto); else passed++;
        @(negedge clock);
        reset = 1'b0;
        np = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock);
            #1;
            if (bus.pronto === 1'b1) np++;
        end
        checks++; if (np != 0) $display("FAIL midcalc_no_pronto: got %0d expected 0", np); else passed++;
        run_op(5'd12, 5'd10, -1);
        checks++; if (prod_tr[7] !== 10'd120) $display("FAIL midcalc_restart_produto: got %0d expected 120", prod_tr[7]); else passed++;
    endtask

    task automatic test_early_exit();
        logic [4:0] mp  [3];
        logic [9:0] exp [3];
        int         el  [3];
        int         lat;
        mp[0] = 5'd1;  exp[0] = 10'd25;
        mp[1] = 5'd4;  exp[1] = 10'd100;
        mp[2] = 5'd16; exp[2] = 10'd400;
`ifdef MULT_EARLY_EXIT_EN
        el[0] = 3; el[1] = 5; el[2] = 7;
`else
        el[0] = 7; el[1] = 7; el[2] = 7;
`endif
        for (int t = 0; t < 3; t++) begin
            run_op(5'd25, mp[t], -1);
            lat = -1;
            for (int j = 0; j < 12; j++) if (pr_tr[j] === 1'b1 && lat < 0) lat = j;
            checks++;
            if (lat != el[t]) $display("FAIL early_latency[%0d]: got %0d expected %0d", t, lat, el[t]);
            else passed++;
            checks++;
            if (lat < 0 || prod_tr[lat] !== exp[t]) $display("FAIL early_produto[%0d]: got %0d expected %0d", t, (lat < 0) ? 0 : prod_tr[lat], exp[t]);
            else passed++;
        end
    endtask

    initial begin
        checks            = 0;
        passed            = 0;
        reset             = 1'b1;
        bus.iniciar       = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        test_basic();
        test_idle_reset();
        test_max_zero();
        test_busy_ignored();
        test_reset_mid_calc();
        test_early_exit();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
